// File: rtl/stage_mem_hs.sv
// stage_mem_hs: memory/I-O pipeline stage between execute and writeback.
// Issues one req/ack transaction at a time on either the data-memory port
// or the I/O port. It aligns byte lanes, detects bad-size and misaligned
// accesses, times out a silent bus, and returns an extended load result
// with a fault code.
module stage_mem_hs #(
  parameter int DW      = 32,
  parameter int IO_AW   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exn,
  input  logic              ex_valid,
  input  logic              ex_mem_r,
  input  logic              ex_mem_w,
  input  logic              ex_io_r,
  input  logic              ex_io_w,
  input  logic [1:0]        ex_sz,
  input  logic              ex_sx,
  input  logic [DW-1:0]     ex_addr,
  input  logic [DW-1:0]     ex_wdata,
  output logic              stall,
  output logic              res_valid,
  output logic [DW-1:0]     res,
  output logic [1:0]        fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW-1:0]     mem_addr,
  output logic [DW/8-1:0]   mem_be,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [IO_AW-1:0]  io_addr,
  output logic [DW-1:0]     io_wdata,
  input  logic              io_ack,
  input  logic [DW-1:0]     io_rdata
);

  localparam int NB = DW / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] F_NONE     = 2'd0;
  localparam logic [1:0] F_MISALIGN = 2'd1;
  localparam logic [1:0] F_TIMEOUT  = 2'd2;
  localparam logic [1:0] F_BADSIZE  = 2'd3;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic            r_kill;
  logic            r_is_io;
  logic            r_load;
  logic [OB-1:0]   r_off;
  logic [1:0]      r_sz;
  logic            r_sx;
  logic [CW-1:0]   r_cnt;

  logic            w_is_mem;
  logic            w_is_io;
  logic            w_accept;
  logic [OB-1:0]   w_off;
  logic            w_bad_sz;
  logic            w_misalign;
  logic [NB-1:0]   w_be_base;
  logic [NB-1:0]   w_be;
  logic [DW-1:0]   w_wrep;
  logic            w_ack;
  logic            w_tmo;
  logic            w_kill;
  logic [DW-1:0]   w_rsel;
  logic [DW-1:0]   w_shift;
  logic [DW-1:0]   w_mask;
  logic            w_sign;
  logic [DW-1:0]   w_ld;

  assign stall = (r_state == S_BUSY);

  // Accept decode: memory flags take priority over I/O flags
  always_comb begin
    w_is_mem = ex_mem_r | ex_mem_w;
    w_is_io  = ex_io_r | ex_io_w;
    w_accept = (r_state == S_IDLE) && ex_valid && !exn && (w_is_mem || w_is_io);
    w_off    = ex_addr[OB-1:0];
    w_bad_sz = (ex_sz == 2'd3) && (DW == 32);
  end

  // Alignment check, byte enables and lane-replicated store data
  always_comb begin
    w_misalign = 1'b0;
    w_be_base  = '0;
    w_wrep     = ex_wdata;
    case (ex_sz)
      2'd0: begin
        w_be_base = NB'(8'h01);
        w_wrep    = {NB{ex_wdata[7:0]}};
      end
      2'd1: begin
        w_misalign = ex_addr[0];
        w_be_base  = NB'(8'h03);
        w_wrep     = {(DW/16){ex_wdata[15:0]}};
      end
      2'd2: begin
        w_misalign = |ex_addr[1:0];
        w_be_base  = NB'(8'h0F);
        w_wrep     = {(DW/32){ex_wdata[31:0]}};
      end
      default: begin
        w_misalign = |ex_addr[2:0];
        w_be_base  = NB'(8'hFF);
        w_wrep     = ex_wdata;
      end
    endcase
    w_be = w_be_base << w_off;
  end

  // Completion sources and load-result extraction from the acked read data
  always_comb begin
    w_ack   = r_is_io ? io_ack : mem_ack;
    w_rsel  = r_is_io ? io_rdata : mem_rdata;
    w_tmo   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
    w_kill  = r_kill | exn;
    w_shift = w_rsel >> {r_off, 3'b000};
    w_mask  = '1;
    w_sign  = w_shift[DW-1];
    case (r_sz)
      2'd0: begin
        w_mask = DW'(8'hFF);
        w_sign = w_shift[7];
      end
      2'd1: begin
        w_mask = DW'(16'hFFFF);
        w_sign = w_shift[15];
      end
      2'd2: begin
        w_mask = DW'(32'hFFFF_FFFF);
        w_sign = w_shift[31];
      end
      default: begin
        w_mask = '1;
        w_sign = w_shift[DW-1];
      end
    endcase
    // Sign extension fills every bit above the access width
    w_ld = (w_shift & w_mask) | ((r_sx && w_sign) ? ~w_mask : '0);
  end

  // Access FSM with registered bus requests and result/fault outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_kill    <= 1'b0;
      r_is_io   <= 1'b0;
      r_load    <= 1'b0;
      r_off     <= '0;
      r_sz      <= '0;
      r_sx      <= 1'b0;
      r_cnt     <= '0;
      res_valid <= 1'b0;
      res       <= '0;
      fault     <= F_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
    end else begin
      res_valid <= 1'b0;
      res       <= '0;
      fault     <= F_NONE;
      case (r_state)
        S_IDLE: begin
          r_kill <= 1'b0;
          if (w_accept) begin
            if (w_is_mem) begin
              if (w_bad_sz) begin
                res_valid <= 1'b1;
                fault     <= F_BADSIZE;
              end else if (w_misalign) begin
                res_valid <= 1'b1;
                fault     <= F_MISALIGN;
              end else begin
                r_state   <= S_BUSY;
                r_is_io   <= 1'b0;
                r_load    <= !ex_mem_w;
                r_off     <= w_off;
                r_sz      <= ex_sz;
                r_sx      <= ex_sx;
                r_cnt     <= '0;
                mem_req   <= 1'b1;
                mem_we    <= ex_mem_w;
                mem_addr  <= ex_addr & ~DW'(NB - 1);
                mem_be    <= w_be;
                mem_wdata <= w_wrep;
              end
            end else begin
              r_state  <= S_BUSY;
              r_is_io  <= 1'b1;
              r_load   <= !ex_io_w;
              r_off    <= '0;
              r_sz     <= ex_sz;
              r_sx     <= ex_sx;
              r_cnt    <= '0;
              io_req   <= 1'b1;
              io_we    <= ex_io_w;
              io_addr  <= ex_addr[IO_AW-1:0];
              io_wdata <= ex_wdata;
            end
          end
        end
        S_BUSY: begin
          if (exn) begin
            r_kill <= 1'b1;
          end
          if (w_ack || w_tmo) begin
            // Ack wins over a timeout in the same cycle; a flushed access
            // still has to finish on the bus but reports nothing.
            r_state   <= S_IDLE;
            r_kill    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            io_req    <= 1'b0;
            io_we     <= 1'b0;
            res_valid <= !w_kill;
            fault     <= (w_ack || w_kill) ? F_NONE : F_TIMEOUT;
            res       <= (w_ack && r_load && !w_kill) ? w_ld : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
